play_area_arbiter: RTL and testbench

PLAY_AREA_ARBITER -- requirements
Module: play_area_arbiter

---
 rtl/play_area_pkg.sv | 10 +
 rtl/play_area_sweep.sv | 45 ++++
 rtl/play_area_arbiter.sv | 156 +++++++++++++++
 tb/tb_play_area_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/play_area_pkg.sv
// Shared cell codes, RAM-owner and FSM encodings for the play-area arbiter.
package play_area_pkg;

   typedef enum logic [1:0] {NONE, VID, GAME, SWEEP} owner_t;
   typedef enum logic {CLEAR, RUN} state_t;

   localparam logic [2:0] CELL_EMPTY = 3'd0;
   localparam logic [2:0] CELL_WALL  = 3'd1;

endpackage

// File: rtl/play_area_sweep.sv
// Raster counter for the clear sweep: walks x fastest, then y, and flags
// border cells so the current cell value is known without a lookup.
module play_area_sweep
   import play_area_pkg::*;
#(
   parameter int WIDTH = 80,
   parameter int HEIGHT = 60,
   parameter int BIT_DEPTH = 3,
   parameter logic [BIT_DEPTH-1:0] WALL_VALUE = BIT_DEPTH'(CELL_WALL),
   localparam int XW = $clog2(WIDTH),
   localparam int YW = $clog2(HEIGHT)
)(
   input  logic                 clk,
   input  logic                 advance,
   input  logic                 restart,
   output logic [XW-1:0]        x,
   output logic [YW-1:0]        y,
   output logic [BIT_DEPTH-1:0] wdata,
   output logic                 done
);

   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

   logic border;

   always_ff @(posedge clk) begin
      if (restart) begin
         x <= '0;
         y <= '0;
      end else if (advance) begin
         if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

   assign border = (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);
   assign wdata  = border ? WALL_VALUE : BIT_DEPTH'(CELL_EMPTY);
   assign done   = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/play_area_arbiter.sv
// Single-port play-area RAM arbiter: video scanout has priority, game logic
// gets the RAM when video is idle or after a bounded starvation run.
module play_area_arbiter
   import play_area_pkg::*;
#(
   parameter int WIDTH = 80,
   parameter int HEIGHT = 60,
   parameter int BIT_DEPTH = 3,
   parameter logic [BIT_DEPTH-1:0] WALL_VALUE = BIT_DEPTH'(CELL_WALL),
   parameter int STARVE_LIMIT = 8,
   localparam int XW = $clog2(WIDTH),
   localparam int YW = $clog2(HEIGHT)
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 vid_req,
   input  logic [XW-1:0]        vid_x,
   input  logic [YW-1:0]        vid_y,
   output logic                 vid_rvalid,
   output logic [BIT_DEPTH-1:0] vid_rdata,
   input  logic                 game_req,
   input  logic                 game_we,
   input  logic [XW-1:0]        game_x,
   input  logic [YW-1:0]        game_y,
   input  logic [BIT_DEPTH-1:0] game_wdata,
   output logic                 game_ack,
   output logic                 game_rvalid,
   output logic [BIT_DEPTH-1:0] game_rdata,
   input  logic                 clear_req,
   output logic                 busy,
   output logic [XW-1:0]        pa_x,
   output logic [YW-1:0]        pa_y,
   output logic                 pa_we,
   output logic [BIT_DEPTH-1:0] pa_wdata,
   input  logic [BIT_DEPTH-1:0] pa_out
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   state_t               state, state_next;
   owner_t               owner, resp_owner;
   logic [SW-1:0]        starve_cnt;
   logic                 starve_full;
   logic [BIT_DEPTH-1:0] vid_hold, game_hold;
   logic [XW-1:0]        sweep_x;
   logic [YW-1:0]        sweep_y;
   logic [BIT_DEPTH-1:0] sweep_wdata;
   logic                 sweep_done;

   play_area_sweep #(
      .WIDTH      (WIDTH),
      .HEIGHT     (HEIGHT),
      .BIT_DEPTH  (BIT_DEPTH),
      .WALL_VALUE (WALL_VALUE)
   ) u_sweep (
      .clk     (clk),
      .advance (owner == SWEEP),
      .restart (reset || clear_req),
      .x       (sweep_x),
      .y       (sweep_y),
      .wdata   (sweep_wdata),
      .done    (sweep_done)
   );

   assign starve_full = (starve_cnt == SW'(STARVE_LIMIT));

   always_ff @(posedge clk) begin
      if (reset) state <= CLEAR;
      else       state <= state_next;
   end

   // A restart request always wins over the sweep finishing in the same cycle.
   always_comb begin
      state_next = state;
      case (state)
         CLEAR: begin
            if (clear_req)                         state_next = CLEAR;
            else if (owner == SWEEP && sweep_done) state_next = RUN;
         end
         RUN: begin
            if (clear_req) state_next = CLEAR;
         end
         default: state_next = CLEAR;
      endcase
   end

   always_comb begin
      owner = NONE;
      if (vid_req && !(starve_full && game_req && state == RUN)) owner = VID;
      else if (state == RUN && game_req)                        owner = GAME;
      else if (state == CLEAR)                                  owner = SWEEP;
   end

   always_comb begin
      pa_x     = '0;
      pa_y     = '0;
      pa_we    = 1'b0;
      pa_wdata = '0;
      case (owner)
         VID: begin
            pa_x = vid_x;
            pa_y = vid_y;
         end
         GAME: begin
            pa_x     = game_x;
            pa_y     = game_y;
            pa_we    = game_we;
            pa_wdata = game_wdata;
         end
         SWEEP: begin
            pa_x     = sweep_x;
            pa_y     = sweep_y;
            pa_we    = 1'b1;
            pa_wdata = sweep_wdata;
         end
         default: ;
      endcase
   end

   assign game_ack = (owner == GAME);
   assign busy     = (state == CLEAR);

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (game_req && state == RUN && owner != GAME) begin
         if (!starve_full) starve_cnt <= starve_cnt + 1'b1;
      end else begin
         starve_cnt <= '0;
      end
   end

   // The RAM answers one cycle late, so remember who asked.
   always_ff @(posedge clk) begin
      if (reset)                          resp_owner <= NONE;
      else if (owner == VID)              resp_owner <= VID;
      else if (owner == GAME && !game_we) resp_owner <= GAME;
      else                                resp_owner <= NONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vid_hold  <= '0;
         game_hold <= '0;
      end else begin
         if (resp_owner == VID)  vid_hold  <= pa_out;
         if (resp_owner == GAME) game_hold <= pa_out;
      end
   end

   assign vid_rvalid  = (resp_owner == VID);
   assign game_rvalid = (resp_owner == GAME);
   assign vid_rdata   = vid_rvalid  ? pa_out : vid_hold;
   assign game_rdata  = game_rvalid ? pa_out : game_hold;

endmodule

// File: tb/tb_play_area_arbiter.sv
// Self-checking bench for play_area_arbiter: cell-index reference model,
// directed vector table, multi-cycle corner sequences and random traffic.
module tb_play_area_arbiter;

   localparam int W = 80;
   localparam int H = 60;
   localparam int LIMIT = 8;
   localparam int CELLS = W * H;

   typedef struct {
      logic rst, vr, gr, gwe, clr;
      int   vx, vy, gx, gy, gwd;
   } req_t;

   typedef struct {
      req_t r;
      logic ack, vrv, grv;
      int   vrd, grd;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset, vid_req, vid_rvalid, game_req, game_we, game_ack, game_rvalid;
   logic       clear_req, busy, pa_we;
   logic [6:0] vid_x, game_x, pa_x;
   logic [5:0] vid_y, game_y, pa_y;
   logic [2:0] vid_rdata, game_wdata, game_rdata, pa_wdata, pa_out;

   logic [2:0] mem [0:H-1][0:W-1];

   int total = 0;
   int bad = 0;

   // reference model state: clear progress as a linear cell index
   int   shadow [0:H-1][0:W-1];
   logic m_known = 1'b0;
   logic m_clear, m_vp, m_gp;
   int   m_idx, m_starve, m_vd, m_gd;

   logic s_busy, s_ack, s_vrv, s_grv;
   int   s_vrd, s_grd;

   vec_t vecs [10];

   play_area_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .vid_req     (vid_req),
      .vid_x       (vid_x),
      .vid_y       (vid_y),
      .vid_rvalid  (vid_rvalid),
      .vid_rdata   (vid_rdata),
      .game_req    (game_req),
      .game_we     (game_we),
      .game_x      (game_x),
      .game_y      (game_y),
      .game_wdata  (game_wdata),
      .game_ack    (game_ack),
      .game_rvalid (game_rvalid),
      .game_rdata  (game_rdata),
      .clear_req   (clear_req),
      .busy        (busy),
      .pa_x        (pa_x),
      .pa_y        (pa_y),
      .pa_we       (pa_we),
      .pa_wdata    (pa_wdata),
      .pa_out      (pa_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pa_we && !reset) mem[pa_y][pa_x] <= pa_wdata;
      pa_out <= mem[pa_y][pa_x];
   end

   function automatic req_t mk(input logic rst, input logic vr, input int vx, input int vy,
                               input logic gr, input logic gwe, input int gx, input int gy,
                               input int gwd, input logic clr);
      req_t r;
      r.rst = rst; r.vr = vr; r.vx = vx; r.vy = vy;
      r.gr = gr; r.gwe = gwe; r.gx = gx; r.gy = gy; r.gwd = gwd; r.clr = clr;
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock cycle: drive, compare against the model, then advance the model.
   task automatic applyStimulus(input req_t r);
      int own, ex, ey, ewe, ewd, cx, cy;
      logic was_clear, nvp, ngp;
      reset = r.rst; vid_req = r.vr; vid_x = 7'(r.vx); vid_y = 6'(r.vy);
      game_req = r.gr; game_we = r.gwe; game_x = 7'(r.gx); game_y = 6'(r.gy);
      game_wdata = 3'(r.gwd); clear_req = r.clr;
      #1;
      s_busy = busy; s_ack = game_ack; s_vrv = vid_rvalid; s_grv = game_rvalid;
      s_vrd = int'(vid_rdata); s_grd = int'(game_rdata);

      if (r.vr && !(m_starve == LIMIT && r.gr && !m_clear)) own = 1;
      else if (!m_clear && r.gr)                             own = 2;
      else if (m_clear)                                      own = 3;
      else                                                   own = 0;
      cx = m_idx % W;
      cy = m_idx / W;
      ex = 0; ey = 0; ewe = 0; ewd = 0;
      case (own)
         1: begin ex = r.vx; ey = r.vy; end
         2: begin ex = r.gx; ey = r.gy; ewe = int'(r.gwe); ewd = r.gwd; end
         3: begin
            ex = cx; ey = cy; ewe = 1;
            ewd = (cx == 0 || cx == W-1 || cy == 0 || cy == H-1) ? 1 : 0;
         end
         default: ;
      endcase

      if (!r.rst && m_known) begin
         chk("busy", s_busy, int'(m_clear));
         chk("game_ack", s_ack, int'(own == 2));
         chk("vid_rvalid", s_vrv, int'(m_vp));
         chk("vid_rdata", s_vrd, m_vd);
         chk("game_rvalid", s_grv, int'(m_gp));
         chk("game_rdata", s_grd, m_gd);
         chk("pa_we", int'(pa_we), ewe);
         chk("pa_x", int'(pa_x), ex);
         chk("pa_y", int'(pa_y), ey);
         if (ewe != 0) chk("pa_wdata", int'(pa_wdata), ewd);
      end

      @(posedge clk);
      if (r.rst) begin
         m_known = 1'b1; m_clear = 1'b1; m_idx = 0; m_starve = 0;
         m_vp = 1'b0; m_gp = 1'b0; m_vd = 0; m_gd = 0;
      end else if (m_known) begin
         was_clear = m_clear;
         nvp = 1'b0;
         ngp = 1'b0;
         case (own)
            1: begin nvp = 1'b1; m_vd = shadow[r.vy][r.vx]; end
            2: begin
               if (r.gwe) shadow[r.gy][r.gx] = r.gwd;
               else begin ngp = 1'b1; m_gd = shadow[r.gy][r.gx]; end
            end
            3: begin
               shadow[cy][cx] = ewd;
               m_idx++;
               if (m_idx == CELLS) m_clear = 1'b0;
            end
            default: ;
         endcase
         if (r.gr && !was_clear && own != 2) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
         else                                m_starve = 0;
         if (r.clr) begin m_clear = 1'b1; m_idx = 0; end
         m_vp = nvp;
         m_gp = ngp;
      end
      #1;
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      chk($sformatf("vec%0d_ack", idx), s_ack, int'(v.ack));
      chk($sformatf("vec%0d_vrv", idx), s_vrv, int'(v.vrv));
      chk($sformatf("vec%0d_vrd", idx), s_vrd, v.vrd);
      chk($sformatf("vec%0d_grv", idx), s_grv, int'(v.grv));
      chk($sformatf("vec%0d_grd", idx), s_grd, v.grd);
   endtask

   initial begin
      req_t idle;
      int n, k, v, early, badcells;
      logic g_on, g_we;
      int gx, gy, gwd;

      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // freshly cleared field: border=1, interior=0
      vecs[0] = '{mk(0, 0, 0, 0, 1, 1, 10, 20, 4, 0), 1'b1, 1'b0, 1'b0, 0, 0};
      vecs[1] = '{mk(0, 0, 0, 0, 1, 0, 10, 20, 0, 0), 1'b1, 1'b0, 1'b0, 0, 0};
      vecs[2] = '{idle,                               1'b0, 1'b0, 1'b1, 0, 4};
      vecs[3] = '{mk(0, 1, 3, 3, 0, 0, 0, 0, 0, 0),   1'b0, 1'b0, 1'b0, 0, 4};
      vecs[4] = '{mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0),   1'b1, 1'b1, 1'b0, 0, 4};
      vecs[5] = '{idle,                               1'b0, 1'b0, 1'b1, 0, 1};
      vecs[6] = '{mk(0, 1, 79, 59, 1, 0, 5, 5, 0, 0), 1'b0, 1'b0, 1'b0, 0, 1};
      vecs[7] = '{mk(0, 0, 0, 0, 1, 0, 5, 5, 0, 0),   1'b1, 1'b1, 1'b0, 1, 1};
      vecs[8] = '{mk(0, 1, 0, 5, 0, 0, 0, 0, 0, 0),   1'b0, 1'b0, 1'b1, 1, 0};
      vecs[9] = '{idle,                               1'b0, 1'b1, 1'b0, 1, 0};

      applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("reset_vid_rdata", int'(vid_rdata), 0);
      chk("reset_game_rdata", int'(game_rdata), 0);

      // plain clear after reset
      n = 0; k = 0;
      do begin
         applyStimulus(idle);
         if (s_busy) n++;
         k++;
      end while (s_busy && k < 6000);
      chk("clear_busy_cycles", n, CELLS);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].r);
         checkOutput(vecs[i], i);
      end

      // video hogging: game preempts on the 9th waiting cycle
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(mk(0, 1, 2, 2, 1, 0, 1, 1, 0, 0));
         if (s_ack) begin k = i; break; end
      end
      chk("starve_ack_cycle", k, 9);
      applyStimulus(mk(0, 1, 2, 2, 1, 0, 1, 2, 0, 0));
      chk("vid_regrant_ack", s_ack, 0);
      applyStimulus(mk(0, 0, 0, 0, 1, 0, 1, 2, 0, 0));
      applyStimulus(idle);

      // clear while game waits
      applyStimulus(mk(0, 0, 0, 0, 1, 1, 10, 10, 2, 0));
      chk("pre_clear_write_ack", s_ack, 1);
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      early = 0; k = 0;
      do begin
         applyStimulus(mk(0, 0, 0, 0, 1, 0, 10, 10, 0, 0));
         if (s_ack && s_busy) early++;
         k++;
      end while (!s_ack && k < 6000);
      chk("ack_during_clear", early, 0);
      chk("clear_wait_cycles", k, CELLS + 1);
      applyStimulus(idle);
      chk("cleared_cell_rvalid", s_grv, 1);
      chk("cleared_cell_data", s_grd, 0);

      // alternate video reads stretch the sweep
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      n = 0; v = 0; k = 0;
      do begin
         applyStimulus(mk(0, k[0], $urandom_range(0, W-1), $urandom_range(0, H-1), 0, 0, 0, 0, 0, 0));
         if (s_busy) begin
            n++;
            if (k[0]) v++;
         end
         k++;
      end while (s_busy && k < 12000);
      chk("stretched_busy", n, CELLS + v);
      applyStimulus(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      applyStimulus(mk(0, 1, 40, 30, 0, 0, 0, 0, 0, 0));
      chk("wall_0_0", s_vrd, 1);
      applyStimulus(mk(0, 1, 79, 0, 0, 0, 0, 0, 0, 0));
      chk("empty_40_30", s_vrd, 0);
      applyStimulus(idle);
      chk("wall_79_0", s_vrd, 1);

      // reset on the grant cycle of a read
      applyStimulus(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
      applyStimulus(idle);
      chk("rst_suppress_vrv", s_vrv, 0);

      // random traffic against the model
      g_on = 1'b0; g_we = 1'b0; gx = 0; gy = 0; gwd = 0;
      for (int i = 0; i < 12000; i++) begin
         if (!g_on && $urandom_range(0, 2) == 0) begin
            g_on = 1'b1;
            g_we = 1'($urandom_range(0, 1));
            gx = $urandom_range(0, W-1);
            gy = $urandom_range(0, H-1);
            gwd = $urandom_range(0, 7);
         end
         applyStimulus(mk(0, $urandom_range(0, 99) < 60, $urandom_range(0, W-1),
                          $urandom_range(0, H-1), g_on, g_we, gx, gy, gwd,
                          $urandom_range(0, 4999) == 0));
         if (s_ack) g_on = 1'b0;
      end
      applyStimulus(idle);

      badcells = 0;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            if (int'(mem[y][x]) != shadow[y][x]) badcells++;
      chk("ram_image", badcells, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
